cg_immediate_encoder: RTL and testbench

- Streaming instruction compactor that performs the inverse of constant generation. It scans a 16-bit MSP430 instruction word stream and finds immediate operands (#imm, encoded as R0 with As=11) whose value the CG can synthesize. It rewrites the IW to the R2/R3 encoding and drops the extension word.
- Sits between the debug instruction-injection port and the CPU fetch/inject path. It shortens injected instructions.
- PC-relative offsets of downstream code are the injector's responsibility.

---
 rtl/cg_pkg.sv | 32 +++
 rtl/cg_const_match.sv | 41 ++++
 rtl/cg_immediate_encoder.sv | 197 +++++++++++++++++++
 tb/tb_cg_immediate_encoder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cg_pkg.sv
// Shared encodings for the constant-generator immediate encoder.
// Holds register numbers, addressing modes, format masks and the FSM state type.
package cg_pkg;

  localparam logic [3:0] PC  = 4'd0;
  localparam logic [3:0] CG1 = 4'd2;
  localparam logic [3:0] CG2 = 4'd3;

  localparam logic [1:0] REGISTER_MODE               = 2'b00;
  localparam logic [1:0] INDEXED_MODE                = 2'b01;
  localparam logic [1:0] INDIRECT_MODE               = 2'b10;
  localparam logic [1:0] INDIRECT_AUTOINCREMENT_MODE = 2'b11;

  localparam logic [15:0] FMT2_MASK        = 16'hFC00;
  localparam logic [15:0] FMT2_MATCH       = 16'h1000;
  localparam logic [15:0] JUMP_MASK        = 16'hE000;
  localparam logic [15:0] JUMP_MATCH       = 16'h2000;
  localparam logic [2:0]  FMT2_RESERVED_OP = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StEmit
  } cgState_e;

  // A source field costs an extension word for indexed/absolute (not CG2) and #imm.
  function automatic logic srcHasExt(input logic [3:0] srcReg, input logic [1:0] srcAs);
    return ((srcAs == INDEXED_MODE) && (srcReg != CG2)) ||
           ((srcAs == INDIRECT_AUTOINCREMENT_MODE) && (srcReg == PC));
  endfunction

endpackage

// File: rtl/cg_const_match.sv
// Maps an immediate value onto the R2/R3 constant-generator encoding, if one exists.
// Byte operations compare only the low byte of the value.
module cg_const_match
  import cg_pkg::*;
(
  input  logic [15:0] value,
  input  logic        isByte,
  output logic        hit,
  output logic [3:0]  cgReg,
  output logic [1:0]  cgAs
);

  logic [15:0] cmp;
  logic        allOnes;

  always_comb begin
    cmp     = isByte ? {8'h00, value[7:0]} : value;
    allOnes = isByte ? (value[7:0] == 8'hFF) : (value == 16'hFFFF);
    hit     = 1'b1;
    cgReg   = CG2;
    cgAs    = REGISTER_MODE;
    if (cmp == 16'd0) begin
      cgAs = REGISTER_MODE;
    end else if (cmp == 16'd1) begin
      cgAs = INDEXED_MODE;
    end else if (cmp == 16'd2) begin
      cgAs = INDIRECT_MODE;
    end else if (allOnes) begin
      cgAs = INDIRECT_AUTOINCREMENT_MODE;
    end else if (cmp == 16'd4) begin
      cgReg = CG1;
      cgAs  = INDIRECT_MODE;
    end else if (cmp == 16'd8) begin
      cgReg = CG1;
      cgAs  = INDIRECT_AUTOINCREMENT_MODE;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/cg_immediate_encoder.sv
// Collects one MSP430 instruction, folds a CG-expressible #imm into R2/R3 and re-emits it.
// Define CG_ENCODER_STATS_EN to add the saturating saved_count output.
module cg_immediate_encoder
  import cg_pkg::*;
#(
  parameter bit REWRITE_F2 = 1'b1
`ifdef CG_ENCODER_STATS_EN
  ,
  parameter int unsigned COUNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last
`ifdef CG_ENCODER_STATS_EN
  ,
  output logic [COUNT_W-1:0] saved_count
`endif
);

  cgState_e    stateQ, stateD;
  logic        inAccept, outFire;
  logic        isJumpIn, isF1In, isF2In, srcExtIn, dstExtIn, srcImmIn;
  logic [1:0]  nExtIn;
  logic [15:0] iwQ, ext0Q, buf1Q, buf2Q;
  logic [1:0]  nExtQ, extCntQ, remQ;
  logic        immQ, f2Q, rewrittenQ;
  logic        lastExt, rewrite, hit;
  logic [15:0] srcWord, newIw;
  logic [3:0]  cgReg;
  logic [1:0]  cgAs;

  assign in_ready = (stateQ != StEmit);
  assign inAccept = in_valid && in_ready;
  assign outFire  = out_valid && out_ready;

  always_comb begin
    isJumpIn = (in_data & JUMP_MASK) == JUMP_MATCH;
    isF1In   = !isJumpIn && (in_data[15:12] >= 4'd4);
    isF2In   = ((in_data & FMT2_MASK) == FMT2_MATCH) && (in_data[9:7] != FMT2_RESERVED_OP);
    srcExtIn = isF1In ? srcHasExt(in_data[11:8], in_data[5:4])
                      : (isF2In && srcHasExt(in_data[3:0], in_data[5:4]));
    dstExtIn = isF1In && in_data[7] && (in_data[3:0] != CG2);
    srcImmIn = isF1In ? ((in_data[11:8] == PC) &&
                         (in_data[5:4] == INDIRECT_AUTOINCREMENT_MODE))
                      : (REWRITE_F2 && isF2In && (in_data[3:0] == PC) &&
                         (in_data[5:4] == INDIRECT_AUTOINCREMENT_MODE));
    nExtIn   = {1'b0, srcExtIn} + {1'b0, dstExtIn};
  end

  // The source extension always arrives first, so it is either live or in ext0Q.
  assign lastExt = (extCntQ + 2'd1) == nExtQ;
  assign srcWord = (extCntQ == 2'd0) ? in_data : ext0Q;

  cg_const_match uConstMatch (
    .value  (srcWord),
    .isByte (iwQ[6]),
    .hit    (hit),
    .cgReg  (cgReg),
    .cgAs   (cgAs)
  );

  always_comb begin
    rewrite = immQ && hit;
    newIw   = iwQ;
    if (rewrite) begin
      newIw[5:4] = cgAs;
      if (f2Q) newIw[3:0] = cgReg;
      else     newIw[11:8] = cgReg;
    end
  end

  always_comb begin
    stateD = stateQ;
    if (flush) begin
      stateD = StIdle;
    end else begin
      unique case (stateQ)
        StIdle:    if (inAccept) stateD = (nExtIn == 2'd0) ? StEmit : StCollect;
        StCollect: if (inAccept && lastExt) stateD = StEmit;
        StEmit:    if (outFire && out_last) stateD = StIdle;
        default:   stateD = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= StIdle;
    else     stateQ <= stateD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iwQ        <= '0;
      ext0Q      <= '0;
      buf1Q      <= '0;
      buf2Q      <= '0;
      nExtQ      <= '0;
      extCntQ    <= '0;
      remQ       <= '0;
      immQ       <= 1'b0;
      f2Q        <= 1'b0;
      rewrittenQ <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
    end else if (flush) begin
      extCntQ    <= '0;
      remQ       <= '0;
      rewrittenQ <= 1'b0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (inAccept) begin
            iwQ     <= in_data;
            nExtQ   <= nExtIn;
            immQ    <= srcImmIn;
            f2Q     <= isF2In;
            extCntQ <= '0;
            if (nExtIn == 2'd0) begin
              out_data   <= in_data;
              out_valid  <= 1'b1;
              out_first  <= 1'b1;
              out_last   <= 1'b1;
              remQ       <= '0;
              rewrittenQ <= 1'b0;
            end
          end
        end
        StCollect: begin
          if (inAccept) begin
            if (!lastExt) begin
              ext0Q   <= in_data;
              extCntQ <= extCntQ + 2'd1;
            end else begin
              out_data   <= newIw;
              out_valid  <= 1'b1;
              out_first  <= 1'b1;
              rewrittenQ <= rewrite;
              // A rewrite drops the source word; the destination word (if any) stays.
              if (nExtQ == 2'd2) begin
                buf1Q    <= rewrite ? in_data : ext0Q;
                buf2Q    <= in_data;
                remQ     <= rewrite ? 2'd1 : 2'd2;
                out_last <= 1'b0;
              end else begin
                buf1Q    <= in_data;
                remQ     <= rewrite ? 2'd0 : 2'd1;
                out_last <= rewrite;
              end
            end
          end
        end
        StEmit: begin
          if (outFire) begin
            if (remQ == 2'd0) begin
              out_valid <= 1'b0;
              out_first <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_data  <= buf1Q;
              buf1Q     <= buf2Q;
              remQ      <= remQ - 2'd1;
              out_first <= 1'b0;
              out_last  <= (remQ == 2'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CG_ENCODER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saved_count <= '0;
    end else if (!flush && (stateQ == StEmit) && outFire && out_first && rewrittenQ &&
                 (saved_count != {COUNT_W{1'b1}})) begin
      saved_count <= saved_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_cg_immediate_encoder.sv
// Bench for cg_immediate_encoder: fixed vectors, corner sequences and a randomized model check.
// saved_count is checked only when CG_ENCODER_STATS_EN is defined.
module tb_cg_immediate_encoder;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [15:0] in_data;
  logic        in_valid, in_ready, out_valid, out_ready, out_first, out_last;
  logic [15:0] out_data;
  logic        in_valid0, in_ready0, out_valid0, out_ready0, out_first0, out_last0;
  logic [15:0] out_data0;
`ifdef CG_ENCODER_STATS_EN
  logic [15:0] saved_count, saved_count0;
`endif

  int total = 0;
  int bad = 0;
  int nRewrites = 0;

  always #5 clk = ~clk;

  cg_immediate_encoder #(.REWRITE_F2(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last)
`ifdef CG_ENCODER_STATS_EN
    ,
    .saved_count (saved_count)
`endif
  );

  cg_immediate_encoder #(.REWRITE_F2(1'b0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .out_data  (out_data0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .out_first (out_first0),
    .out_last  (out_last0)
`ifdef CG_ENCODER_STATS_EN
    ,
    .saved_count (saved_count0)
`endif
  );

  typedef struct packed {
    logic [2:0][15:0] w;
    logic [1:0]       nIn;
    logic [2:0][15:0] e;
    logic [1:0]       nOut;
    logic [1:0]       stall;
    logic             rew;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, b, c, input int ni,
                              input logic [15:0] x, y, z, input int no,
                              input int st, input bit rw);
    vec_t v;
    v.w     = {c, b, a};
    v.nIn   = 2'(ni);
    v.e     = {z, y, x};
    v.nOut  = 2'(no);
    v.stall = 2'(st);
    v.rew   = rw;
    return v;
  endfunction

  // ---- reference model, straight from the instruction-set rules ----
  function automatic int srcExtM(input int r, input int as);
    return ((as == 1 && r != 3) || (as == 3 && r == 0)) ? 1 : 0;
  endfunction

  function automatic bit isF1M(input logic [15:0] iw);
    return int'(iw[15:12]) >= 4;
  endfunction

  function automatic bit isF2M(input logic [15:0] iw);
    return (iw[15:10] == 6'b000100) && (iw[9:7] != 3'd7);
  endfunction

  function automatic int nExtM(input logic [15:0] iw);
    if (isF1M(iw)) return srcExtM(int'(iw[11:8]), int'(iw[5:4])) +
                          ((iw[7] && iw[3:0] != 4'd3) ? 1 : 0);
    if (isF2M(iw)) return srcExtM(int'(iw[3:0]), int'(iw[5:4]));
    return 0;
  endfunction

  task automatic model(input logic [15:0] iw, x0, x1, output int nIn,
                       output logic [2:0][15:0] e, output int nOut, output bit rew);
    int vals[6] = '{0, 1, 2, 'hFFFF, 4, 8};
    logic [15:0] q[$];
    bit imm;
    int hitIdx = -1;
    nIn = 1 + nExtM(iw);
    imm = (isF1M(iw) && iw[11:8] == 4'd0 && iw[5:4] == 2'd3) ||
          (isF2M(iw) && iw[3:0] == 4'd0 && iw[5:4] == 2'd3);
    if (imm) begin
      for (int i = 0; i < 6; i++) begin
        int tgt = iw[6] ? (vals[i] & 'hFF) : vals[i];
        int v   = iw[6] ? (int'(x0) & 'hFF) : int'(x0);
        if (hitIdx < 0 && v == tgt) hitIdx = i;
      end
    end
    rew = (hitIdx >= 0);
    if (rew) begin
      int r  = (hitIdx < 4) ? 3 : 2;
      int as = (hitIdx < 4) ? hitIdx : hitIdx - 2;
      int niw = isF1M(iw) ? ((int'(iw) & 'hF0CF) | (r << 8) | (as << 4))
                          : ((int'(iw) & 'hFFC0) | (as << 4) | r);
      q.push_back(16'(niw));
      if (nIn == 3) q.push_back(x1);
    end else begin
      q.push_back(iw);
      if (nIn >= 2) q.push_back(x0);
      if (nIn == 3) q.push_back(x1);
    end
    nOut = q.size();
    e = '0;
    for (int i = 0; i < nOut; i++) e[i] = q[i];
  endtask

  // ---- drivers ----
  task automatic putWord(input logic [15:0] w);
    int t = 0;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic getWord(input string name, input logic [15:0] expD, input bit expF,
                         input bit expL, input int stall);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      chk({name, " out_valid timeout"}, 0, 1);
      return;
    end
    for (int s = 0; s < stall; s++) begin
      chk({name, " stall valid"}, out_valid, 1);
      chk({name, " stall data"}, out_data, expD);
      chk({name, " stall first/last"}, {out_first, out_last}, {expF, expL});
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk({name, " data"}, out_data, expD);
    chk({name, " first"}, out_first, expF);
    chk({name, " last"}, out_last, expL);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic runInstr(input string name, input logic [2:0][15:0] w, input int nIn,
                          input logic [2:0][15:0] e, input int nOut, input int stall,
                          input bit rew);
    for (int i = 0; i < nIn; i++) putWord(w[i]);
    chk({name, " latency"}, out_valid, 1);
    for (int k = 0; k < nOut; k++) getWord(name, e[k], k == 0, k == nOut - 1, stall);
    @(negedge clk);
    chk({name, " idle valid"}, out_valid, 0);
    chk({name, " idle in_ready"}, in_ready, 1);
    if (rew) nRewrites++;
`ifdef CG_ENCODER_STATS_EN
    chk({name, " saved_count"}, saved_count, 32'(nRewrites));
`endif
  endtask

  vec_t vecs[15];
  logic [15:0] extPool[9] = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF, 16'h0004,
                              16'h0008, 16'h12FF, 16'hAB01, 16'h1234};

  initial begin
    rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_first/last", {out_first, out_last}, 0);
    chk("reset out_data", out_data, 0);
`ifdef CG_ENCODER_STATS_EN
    chk("reset saved_count", saved_count, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", in_ready, 1);

    vecs[0]  = mk(16'h4035, 16'h0001, 16'h0, 2, 16'h4315, 16'h0, 16'h0, 1, 0, 1);
    vecs[1]  = mk(16'h4035, 16'h1234, 16'h0, 2, 16'h4035, 16'h1234, 16'h0, 2, 0, 0);
    vecs[2]  = mk(16'h5076, 16'h12FF, 16'h0, 2, 16'h5376, 16'h0, 16'h0, 1, 0, 1);
    vecs[3]  = mk(16'h1230, 16'h0008, 16'h0, 2, 16'h1232, 16'h0, 16'h0, 1, 0, 1);
    vecs[4]  = mk(16'h40B7, 16'h0002, 16'h0004, 3, 16'h43A7, 16'h0004, 16'h0, 2, 3, 1);
    vecs[5]  = mk(16'h3C00, 16'h0, 16'h0, 1, 16'h3C00, 16'h0, 16'h0, 1, 0, 0);
    vecs[6]  = mk(16'h4075, 16'h0004, 16'h0, 2, 16'h4265, 16'h0, 16'h0, 1, 1, 1);
    vecs[7]  = mk(16'h4035, 16'hFFFF, 16'h0, 2, 16'h4335, 16'h0, 16'h0, 1, 0, 1);
    vecs[8]  = mk(16'h4035, 16'h00FF, 16'h0, 2, 16'h4035, 16'h00FF, 16'h0, 2, 0, 0);
    vecs[9]  = mk(16'h4215, 16'h0200, 16'h0, 2, 16'h4215, 16'h0200, 16'h0, 2, 2, 0);
    vecs[10] = mk(16'h4583, 16'h0, 16'h0, 1, 16'h4583, 16'h0, 16'h0, 1, 0, 0);
    vecs[11] = mk(16'h13B0, 16'h0, 16'h0, 1, 16'h13B0, 16'h0, 16'h0, 1, 0, 0);
    vecs[12] = mk(16'h12B0, 16'h0004, 16'h0, 2, 16'h12A2, 16'h0, 16'h0, 1, 0, 1);
    vecs[13] = mk(16'h40B2, 16'h0008, 16'h0200, 3, 16'h42B2, 16'h0200, 16'h0, 2, 1, 1);
    vecs[14] = mk(16'h4075, 16'h3400, 16'h0, 2, 16'h4345, 16'h0, 16'h0, 1, 0, 1);

    for (int i = 0; i < 15; i++)
      runInstr($sformatf("vec%0d", i), vecs[i].w, int'(vecs[i].nIn), vecs[i].e,
               int'(vecs[i].nOut), int'(vecs[i].stall), vecs[i].rew);

    // PUSH #8 on the instance that leaves Format 2 alone
    @(negedge clk); in_data = 16'h1230; in_valid0 = 1'b1;
    @(negedge clk); in_data = 16'h0008;
    @(negedge clk); in_valid0 = 1'b0;
    chk("f2off valid", out_valid0, 1);
    chk("f2off iw", out_data0, 16'h1230);
    chk("f2off iw first/last", {out_first0, out_last0}, 2'b10);
    out_ready0 = 1'b1;
    @(negedge clk);
    chk("f2off ext", out_data0, 16'h0008);
    chk("f2off ext first/last", {out_first0, out_last0}, 2'b01);
    @(negedge clk); out_ready0 = 1'b0;
    chk("f2off done", out_valid0, 0);
`ifdef CG_ENCODER_STATS_EN
    chk("f2off saved_count", saved_count0, 0);
`endif

    // flush mid-collect, then a jump must come out on its own
    putWord(16'h40B7);
    putWord(16'h0002);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
`ifdef CG_ENCODER_STATS_EN
    chk("flush saved_count", saved_count, 32'(nRewrites));
`endif
    runInstr("post-flush jmp", {16'h0, 16'h0, 16'h3C00}, 1, {16'h0, 16'h0, 16'h3C00}, 1, 0, 0);

    // reset in the middle of emitting
    putWord(16'h4035);
    putWord(16'h1234);
    @(negedge clk);
    chk("pre-rst valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst in_ready", in_ready, 1);
    nRewrites = 0;

    for (int n = 0; n < 150; n++) begin
      logic [15:0] iw, x0, x1;
      logic [2:0][15:0] e;
      int nIn, nOut;
      bit rew;
      iw = 16'($urandom);
      case ($urandom_range(0, 4))
        0: begin iw[15:12] = 4'($urandom_range(4, 15)); iw[11:8] = 4'd0; iw[5:4] = 2'd3; end
        1: iw[15:12] = 4'($urandom_range(4, 15));
        2: begin
          iw[15:10] = 6'b000100;
          if ($urandom_range(0, 1) == 1) begin iw[3:0] = 4'd0; iw[5:4] = 2'd3; end
        end
        3: iw[15:13] = 3'b001;
        default: ;
      endcase
      x0 = ($urandom_range(0, 3) != 0) ? extPool[$urandom_range(0, 8)] : 16'($urandom);
      x1 = 16'($urandom);
      model(iw, x0, x1, nIn, e, nOut, rew);
      runInstr($sformatf("rnd%0d iw=%h", n, iw), {x1, x0, iw}, nIn, e, nOut,
               $urandom_range(0, 2), rew);
    end

    $display("info: rewritten instructions since last reset=%0d", nRewrites);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
